// File: rtl/exp5_condiciona_jogada.sv
// exp5_condiciona_jogada
// Conditions the raw board inputs of the game into clean, single-cycle events.
// The key switches are synchronized, debounced by a Moore FSM and latched as
// the current "jogada". The start button is synchronized and edge-detected
// into a one-cycle pulse that is followed by a short hold-off window.
//
// Ports:
//   clock          system clock, all flops on the rising edge
//   reset          asynchronous, active-low reset
//   chaves[3:0]    raw key switches (asynchronous to clock)
//   iniciar        raw start button (asynchronous to clock)
//   jogada[3:0]    last accepted key value
//   jogada_feita   one-cycle pulse while a new jogada is being accepted
//   jogada_valida  1 when the accepted jogada has exactly one key pressed
//   iniciar_pulso  one-cycle pulse on a start-button press
//   db_estado[3:0] FSM state code for the debug seven-segment display
module exp5_condiciona_jogada #(
  parameter int N_DEBOUNCE = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       iniciar,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_valida,
  output logic       iniciar_pulso,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(N_DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N_DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [3:0] {
    ESPERA   = 4'd0,
    FILTRA   = 4'd1,
    REGISTRA = 4'd2,
    SOLTA    = 4'd3
  } state_t;

  state_t          state;
  logic [3:0]      chaves_m;
  logic [3:0]      chaves_s;
  logic            iniciar_m;
  logic            iniciar_s;
  logic            iniciar_d;
  logic [3:0]      sample;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   hold;

  // Two-flop synchronizers; only the second stage is used by the logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chaves_m  <= 4'b0000;
      chaves_s  <= 4'b0000;
      iniciar_m <= 1'b0;
      iniciar_s <= 1'b0;
    end else begin
      chaves_m  <= chaves;
      chaves_s  <= chaves_m;
      iniciar_m <= iniciar;
      iniciar_s <= iniciar_m;
    end
  end

  // Debounce FSM. The counter counts matching samples in FILTRA and
  // consecutive all-zero samples in SOLTA, so a key must be released cleanly
  // before the next press can be considered. jogada_feita is registered and
  // set on the edge that enters REGISTRA, so it is high exactly while the FSM
  // sits in REGISTRA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ESPERA;
      sample        <= 4'b0000;
      cnt           <= '0;
      jogada        <= 4'b0000;
      jogada_valida <= 1'b0;
      jogada_feita  <= 1'b0;
    end else begin
      jogada_feita <= 1'b0;
      case (state)
        ESPERA: begin
          if (chaves_s != 4'b0000) begin
            sample <= chaves_s;
            cnt    <= '0;
            state  <= FILTRA;
          end
        end
        FILTRA: begin
          if (chaves_s == 4'b0000) begin
            cnt   <= '0;
            state <= ESPERA;
          end else if (chaves_s == sample) begin
            if (cnt == CNT_LAST) begin
              cnt          <= '0;
              jogada_feita <= 1'b1;
              state        <= REGISTRA;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            // A different key combination restarts the filter window.
            sample <= chaves_s;
            cnt    <= '0;
          end
        end
        REGISTRA: begin
          jogada        <= sample;
          jogada_valida <= $onehot(sample);
          cnt           <= '0;
          state         <= SOLTA;
        end
        SOLTA: begin
          if (chaves_s != 4'b0000) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ESPERA;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ESPERA;
        end
      endcase
    end
  end

  // Start-button edge detector with its own hold-off counter. The pulse is a
  // gate of flop outputs so it lines up with the cycle in which iniciar_s has
  // just risen; the hold-off is loaded on that pulse and counts down to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iniciar_d <= 1'b0;
      hold      <= '0;
    end else begin
      iniciar_d <= iniciar_s;
      if (iniciar_pulso) begin
        hold <= CNT_MAX;
      end else if (hold != '0) begin
        hold <= hold - CNT_ONE;
      end
    end
  end

  assign iniciar_pulso = iniciar_s & ~iniciar_d & (hold == '0);
  assign db_estado     = state;

endmodule

// File: doc/exp5_condiciona_jogada.md
EXP5_CONDICIONA_JOGADA -- requirements
Module: exp5_condiciona_jogada

Interface
REQ-001 The block SHALL have one parameter: N_DEBOUNCE, default 5, the number of consecutive stable synchronized samples a value must hold to be accepted (legal range 2..255).
REQ-002 The block SHALL have these ports, clock and reset first:
- clock  input  1  single system clock; all flops on the rising edge.
- reset  input  1  asynchronous, active-low (reset=0 resets).
- chaves  input  4  raw, unsynchronized key switches from the board.
- iniciar  input  1  raw, unsynchronized start button.
- jogada  output  4  last accepted key value, registered.
- jogada_feita  output  1  one-cycle pulse when a new jogada is accepted.
- jogada_valida  output  1  registered; 1 iff the accepted jogada is one-hot.
- iniciar_pulso  output  1  one-cycle pulse on an iniciar press.
- db_estado  output  4  FSM state code, for the hexa7seg debug display.

Function
REQ-003 chaves and iniciar SHALL each pass through a 2-flop synchronizer; all internal logic SHALL use only the synchronized copies (chaves_s, iniciar_s).
REQ-004 The FSM SHALL be Moore with these states and db_estado codes: ESPERA=0, FILTRA=1, REGISTRA=2, SOLTA=3; unused codes SHALL go to ESPERA.
REQ-005 In ESPERA: chaves_s != 0 SHALL capture chaves_s into an internal sample register, clear the debounce counter, and go to FILTRA.
REQ-006 In FILTRA:
- chaves_s == sample: counter +1; on a match with counter == N_DEBOUNCE-1, go to REGISTRA.
- chaves_s != sample and chaves_s != 0: reload sample, clear counter, stay in FILTRA.
- chaves_s == 0: go to ESPERA.
REQ-007 In REGISTRA (exactly one cycle): jogada_feita=1; on the exit edge jogada <= sample and jogada_valida <= (sample is one-hot); then go to SOLTA.
REQ-008 In SOLTA: the counter SHALL count consecutive cycles with chaves_s == 0 and clear on any nonzero sample. At N_DEBOUNCE consecutive zeros the FSM SHALL go to ESPERA. Key changes while in SOLTA SHALL never produce a jogada_feita.
REQ-009 Latency: take the first rising edge that samples a new stable raw value as edge 1. jogada_feita SHALL be high from edge 3+N_DEBOUNCE to edge 4+N_DEBOUNCE. jogada SHALL show the new value from edge 4+N_DEBOUNCE.
REQ-010 jogada and jogada_valida SHALL hold their values until the next REGISTRA; jogada_feita SHALL be 0 in every state except REGISTRA.
REQ-011 iniciar_pulso SHALL be 1 for exactly one cycle when iniciar_s goes 0->1 (iniciar_s=1 and previous-cycle iniciar_s=0).
REQ-012 After each iniciar_pulso, further rises of iniciar_s SHALL be ignored for N_DEBOUNCE cycles. This hold-off SHALL use a counter independent of the FSM counter.
REQ-013 The iniciar path and the chaves path SHALL operate independently; simultaneous events on both SHALL each produce their own pulse.
REQ-014 The counter SHALL saturate and never wrap; its width SHALL be ceil(log2(N_DEBOUNCE+1)).

Reset
REQ-015 While reset=0, regardless of clock: state=ESPERA, and synchronizers, sample, both counters, jogada, jogada_valida, jogada_feita and iniciar_pulso SHALL be 0, so db_estado=0.
REQ-016 Reset asserted mid-operation (any state) SHALL abort the jogada in progress with no pulse. Release SHALL take effect on the next rising edge.
REQ-017 A key held through reset release SHALL be treated as a new press and accepted per REQ-009. The same SHALL hold for iniciar: a button held through reset release SHALL yield one iniciar_pulso.

Verification
REQ-018 Scenario clean press: N=5; chaves=4'b0100 held 20 cycles, then 0 for 20 cycles. Required: one jogada_feita at edge 8, jogada=4, jogada_valida=1; db_estado sequence 0,1,2,3,0.
REQ-019 Scenario bounce: chaves toggles 0100/0000 every 2 cycles for 10 cycles, then holds 0100. Required: exactly one jogada_feita, 8 edges after the stable hold begins; no pulse during bouncing.
REQ-020 Scenario invalid/changing key: chaves=0011 held 15 cycles. Required: jogada=3, jogada_valida=0. Separately, 0001 for 3 cycles then 0010 held: only 0010 is accepted.
REQ-021 Scenario release bounce: after acceptance, chaves bounces 0/1000 for 6 cycles, then settles to 0 and a new key 0001 is pressed. Required: no pulse during the bounce; 0001 is accepted only after 5 consecutive zero cycles.
REQ-022 Scenario iniciar: iniciar held 10 cycles, released, and pressed again 2 cycles later. Required: one iniciar_pulso at press 1 and a second pulse only after the 5-cycle hold-off has expired.
REQ-023 Scenario reset in FILTRA: reset=0 for 1 cycle while db_estado=1. Required: all outputs 0 at once, no jogada_feita. The held key is then re-accepted 8 edges after release.
